// File: rtl/ssd_scan_ctrl.sv
// Multiplexed seven-segment scanner for an N-digit display.
// A free-running slot counter steps through the digits. Display inputs are
// captured once per frame so a digit cannot change halfway through a scan.
// Each slot begins with a dead time and then applies a PWM brightness window.
// Digits can be disabled individually, and leading zeros can be blanked.
module ssd_scan_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int SCAN_LOG2   = 18,
    parameter int DEAD_CYCLES = 256,
    parameter int BRIGHT_W    = 4,
    parameter int ACTIVE_LOW  = 1,
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    ClkPort,
    input  logic                    Reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    blank_lz,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   An,
    output logic [7:0]              Cath,
    output logic [IDX_W-1:0]        scan_idx,
    output logic                    frame_tick
);

    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SCAN_LOG2-1:0]  DEAD_C   = SCAN_LOG2'(DEAD_CYCLES);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [7:0]            CATH_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    logic [SCAN_LOG2-1:0]  cnt;
    logic                  started;
    logic [4*NUM_DIGITS-1:0] digits_s;
    logic [NUM_DIGITS-1:0] dp_s;
    logic [NUM_DIGITS-1:0] digit_en_s;
    logic                  blank_lz_s;
    logic [BRIGHT_W-1:0]   brightness_s;

    logic                  slot_end;
    logic                  frame_start;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  lz_run;
    logic [3:0]            cur_nib;
    logic [6:0]            seg;
    logic [7:0]            cath_hi;
    logic                  an_on;
    logic [NUM_DIGITS-1:0] an_hi;

    assign slot_end    = &cnt;
    assign frame_start = !started || (slot_end && (scan_idx == LAST_IDX));

    // Slot counter and digit index; 'started' marks the first cycle after reset as a frame start
    always_ff @(posedge ClkPort or negedge Reset) begin
        if (!Reset) begin
            cnt      <= '0;
            scan_idx <= '0;
            started  <= 1'b0;
        end else begin
            cnt     <= cnt + 1'b1;
            started <= 1'b1;
            if (slot_end) begin
                scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
            end
        end
    end

    // Per-frame snapshot of every display input, plus the one-cycle frame pulse
    always_ff @(posedge ClkPort or negedge Reset) begin
        if (!Reset) begin
            digits_s     <= '0;
            dp_s         <= '0;
            digit_en_s   <= '0;
            blank_lz_s   <= 1'b0;
            brightness_s <= '0;
            frame_tick   <= 1'b0;
        end else begin
            frame_tick <= frame_start;
            if (frame_start) begin
                digits_s     <= digits;
                dp_s         <= dp_in;
                digit_en_s   <= digit_en;
                blank_lz_s   <= blank_lz;
                brightness_s <= brightness;
            end
        end
    end

    // Leading-zero mask: walk down from the top digit while every nibble seen so far is zero
    always_comb begin
        lz_run  = 1'b1;
        lz_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_run     = lz_run & (digits_s[4*i +: 4] == 4'd0);
            lz_mask[i] = blank_lz_s & lz_run & (i != 0);
        end
    end

    // Hex glyph for the addressed digit, {a,b,c,d,e,f,g} asserted high
    always_comb begin
        cur_nib = digits_s[4*scan_idx +: 4];
        seg     = 7'b0000000;
        case (cur_nib)
            4'h0: seg = 7'b1111110;
            4'h1: seg = 7'b0110000;
            4'h2: seg = 7'b1101101;
            4'h3: seg = 7'b1111001;
            4'h4: seg = 7'b0110011;
            4'h5: seg = 7'b1011011;
            4'h6: seg = 7'b1011111;
            4'h7: seg = 7'b1110000;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1111011;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b0011111;
            4'hC: seg = 7'b1001110;
            4'hD: seg = 7'b0111101;
            4'hE: seg = 7'b1001111;
            4'hF: seg = 7'b1000111;
            default: seg = 7'b0000000;
        endcase
    end

    // Cathode and anode values before polarity; disabled digits go fully dark, lz-blanked digits keep dp
    always_comb begin
        cath_hi = 8'h00;
        if (!digit_en_s[scan_idx]) begin
            cath_hi = 8'h00;
        end else if (lz_mask[scan_idx]) begin
            cath_hi = {7'b0000000, dp_s[scan_idx]};
        end else begin
            cath_hi = {seg, dp_s[scan_idx]};
        end
        an_on = (cnt >= DEAD_C) && (cnt[SCAN_LOG2-1 -: BRIGHT_W] < brightness_s);
        an_hi = '0;
        if (an_on) begin
            an_hi[scan_idx] = 1'b1;
        end
    end

    // Registered pin drivers with output polarity applied
    always_ff @(posedge ClkPort or negedge Reset) begin
        if (!Reset) begin
            An   <= AN_OFF;
            Cath <= CATH_OFF;
        end else begin
            An   <= an_hi ^ AN_OFF;
            Cath <= cath_hi ^ CATH_OFF;
        end
    end

endmodule
